// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and hands {instr, addr} to the decoder via valid/ready.
module instr_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] ptr_out
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inf_valid_q, inf_valid_d;
  logic [ADDR_WIDTH-1:0] inf_addr_q, inf_addr_d;
  logic                  inf_kill_q, inf_kill_d;
  logic [DATA_WIDTH-1:0] head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
  logic [ADDR_WIDTH-1:0] head_adr_q, head_adr_d, tail_adr_q, tail_adr_d;
  logic [1:0]            occ_q, occ_d;

  logic       pop, push, issue;
  logic [1:0] base;
  logic [2:0] credit;

  always_comb begin
    pop    = (occ_q != 2'd0) & instr_ready;
    // A return that lands in a jump cycle belongs to the abandoned stream.
    push   = inf_valid_q & ~inf_kill_q & ~jump_en;
    base   = occ_q - {1'b0, pop};
    // Outstanding credit: entries kept after this pop plus the read in flight.
    credit = {1'b0, base} + {2'b00, inf_valid_q};
    issue  = ~reset & enable & ~jump_en & (credit < 3'd2);

    pc_d        = pc_q;
    inf_valid_d = issue;
    inf_addr_d  = inf_addr_q;
    inf_kill_d  = inf_kill_q;
    if (jump_en) begin
      pc_d       = jump_addr;
      inf_kill_d = 1'b1;
    end else if (issue) begin
      pc_d       = pc_q + ADDR_WIDTH'(1);
      inf_addr_d = pc_q;
      inf_kill_d = 1'b0;
    end

    head_dat_d = head_dat_q;
    head_adr_d = head_adr_q;
    tail_dat_d = tail_dat_q;
    tail_adr_d = tail_adr_q;
    if (pop) begin
      head_dat_d = tail_dat_q;
      head_adr_d = tail_adr_q;
    end
    if (push) begin
      if (base == 2'd0) begin
        head_dat_d = mem_data;
        head_adr_d = inf_addr_q;
      end else begin
        tail_dat_d = mem_data;
        tail_adr_d = inf_addr_q;
      end
    end
    occ_d = jump_en ? 2'd0 : base + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      inf_valid_q <= 1'b0;
      inf_addr_q  <= '0;
      inf_kill_q  <= 1'b0;
      head_dat_q  <= '0;
      head_adr_q  <= '0;
      tail_dat_q  <= '0;
      tail_adr_q  <= '0;
      occ_q       <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      inf_valid_q <= inf_valid_d;
      inf_addr_q  <= inf_addr_d;
      inf_kill_q  <= inf_kill_d;
      head_dat_q  <= head_dat_d;
      head_adr_q  <= head_adr_d;
      tail_dat_q  <= tail_dat_d;
      tail_adr_q  <= tail_adr_d;
      occ_q       <= occ_d;
    end
  end

  assign mem_addr    = pc_q;
  assign ptr_out     = pc_q;
  assign mem_rd_en   = issue;
  assign instr_valid = (occ_q != 2'd0);
  assign instr_out   = head_dat_q;
  assign instr_addr  = head_adr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed latency/stall/jump/wrap/reset cycles, then
// random traffic checked by an address-stream scoreboard.
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, enable, jump_en, instr_ready;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] mem_addr, instr_addr, ptr_out;
  logic          mem_rd_en, instr_valid;
  logic [DW-1:0] mem_data, instr_out;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .jump_en(jump_en),
    .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_data(mem_data), .instr_out(instr_out), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .ptr_out(ptr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: one-cycle read latency, garbage when no read was issued.
  logic          rd_s = 1'b0;
  logic [AW-1:0] rd_addr_s = '0;
  always @(posedge clk)
    mem_data <= rd_s ? (32'hA000_0000 + {24'h0, rd_addr_s}) : {16'hDEAD, 16'($urandom)};

  // Scoreboard: the architectural instruction stream is contiguous from the
  // last reset/jump target; expected addresses are queued ahead of delivery.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] fill_next  = '0;
  logic [AW-1:0] fetch_next = '0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    logic [AW-1:0] e;
    rd_s      = mem_rd_en;
    rd_addr_s = mem_addr;
    if (prev_stall) begin
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_addr", {24'b0, instr_addr}, {24'b0, prev_addr});
      chk("hold_data", instr_out, prev_data);
    end
    if (!enable || jump_en || reset) chk("no_rd_en", {31'b0, mem_rd_en}, 32'd0);
    if (reset) begin
      exp_q.delete();
      fill_next  = '0;
      fetch_next = '0;
    end else begin
      if (mem_rd_en) begin
        chk("fetch_addr", {24'b0, mem_addr}, {24'b0, fetch_next});
        fetch_next = fetch_next + 1'b1;
      end
      if (instr_valid && instr_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pop_addr", {24'b0, instr_addr}, {24'b0, e});
          chk("pop_data", instr_out, 32'hA000_0000 + {24'b0, e});
        end
      end
      if (jump_en) begin
        exp_q.delete();
        fill_next  = jump_addr;
        fetch_next = jump_addr;
      end
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(fill_next);
      fill_next = fill_next + 1'b1;
    end
    prev_stall = instr_valid && !instr_ready && !jump_en && !reset;
    prev_addr  = instr_addr;
    prev_data  = instr_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [AW-1:0] a);
    chk({name, "_valid"}, {31'b0, instr_valid}, {31'b0, v});
    if (v) begin
      chk({name, "_addr"}, {24'b0, instr_addr}, {24'b0, a});
      chk({name, "_data"}, instr_out, 32'hA000_0000 + {24'b0, a});
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; jump_en = 1'b0; jump_addr = '0; instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
      chk("rst_ptr", {24'b0, ptr_out}, 32'd0);
      chk("rst_maddr", {24'b0, mem_addr}, 32'd0);
      chk("rst_iout", instr_out, 32'd0);
      chk("rst_iaddr", {24'b0, instr_addr}, 32'd0);
      tick();
    end
    reset = 1'b0;

    for (int k = 0; k < 40; k++) begin
      enable      = !(k == 31 || k == 32);
      instr_ready = !((k >= 5 && k <= 9) || k >= 37);
      jump_en     = (k == 14 || k == 20);
      jump_addr   = (k == 14) ? 8'h40 : 8'hFE;
      @(negedge clk);
      case (k)
        0: begin
          chk("first_rd_en", {31'b0, mem_rd_en}, 32'd1);
          chk("first_maddr", {24'b0, mem_addr}, 32'd0);
          chk_out("k1", 1'b0, 8'h00);
        end
        1: chk_out("k1", 1'b0, 8'h00);
        2: chk_out("k2", 1'b1, 8'h00);
        3: chk_out("k3", 1'b1, 8'h01);
        4: chk_out("k4", 1'b1, 8'h02);
        5, 6, 7, 8, 9: begin
          chk_out("stall", 1'b1, 8'h03);
          chk("stall_rd_en", {31'b0, mem_rd_en}, 32'd0);
        end
        10: chk_out("resume3", 1'b1, 8'h03);
        11: chk_out("resume4", 1'b1, 8'h04);
        12: chk_out("resume5", 1'b1, 8'h05);
        14: chk("jump_rd_en", {31'b0, mem_rd_en}, 32'd0);
        15: begin
          chk("jmp_rd_en", {31'b0, mem_rd_en}, 32'd1);
          chk("jmp_maddr", {24'b0, mem_addr}, 32'h40);
          chk_out("jmp_n1", 1'b0, 8'h00);
        end
        16: chk_out("jmp_n2", 1'b0, 8'h00);
        17: chk_out("jmp_n3", 1'b1, 8'h40);
        18: chk_out("jmp_n4", 1'b1, 8'h41);
        21: begin
          chk("wrap_rd_en", {31'b0, mem_rd_en}, 32'd1);
          chk("wrap_maddr", {24'b0, mem_addr}, 32'hFE);
        end
        23: begin
          chk_out("wrap_fe", 1'b1, 8'hFE);
          chk("wrap_ptr", {24'b0, ptr_out}, 32'h00);
        end
        24: chk_out("wrap_ff", 1'b1, 8'hFF);
        25: chk_out("wrap_00", 1'b1, 8'h00);
        26: chk_out("wrap_01", 1'b1, 8'h01);
        32: chk("pause_deliver", {31'b0, instr_valid}, 32'd1);
        39: chk("pre_rst_full", {31'b0, instr_valid}, 32'd1);
        default: ;
      endcase
      tick();
    end

    reset = 1'b1; enable = 1'b1; jump_en = 1'b0; instr_ready = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_ptr", {24'b0, ptr_out}, 32'd0);
    chk("mid_rst_rd_en", {31'b0, mem_rd_en}, 32'd1);
    tick();
    @(negedge clk);
    chk_out("mid_rst_n1", 1'b0, 8'h00);
    tick();
    @(negedge clk);
    chk_out("mid_rst_n2", 1'b1, 8'h00);
    tick();

    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      enable      = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      jump_en     = ($urandom_range(0, 29) == 0);
      jump_addr   = AW'($urandom);
      reset       = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      tick();
    end
    chk("rand_progress", {31'b0, pops > 300}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
